// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM read port among NREQ requesters.
// Each grant is tagged one-hot and the tag rides a shift pipeline to time rsp_valid.
module rom_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned MXADRB     = 9,
    parameter int unsigned MXDATB     = 11,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                     clka,
    input  logic                     rsta,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*MXADRB-1:0]   req_adr,
    output logic [NREQ-1:0]          gnt,
    input  logic                     hold,
    output logic                     rom_ena,
    output logic [MXADRB-1:0]        rom_addra,
    input  logic [MXDATB-1:0]        rom_douta,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [MXDATB-1:0]        rsp_data,
    input  logic                     cnt_clr,
    output logic [15:0]              gnt_count
);

    localparam int unsigned PTRW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NSTG    = RD_LATENCY + 1;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [PTRW-1:0]             ptr;
    logic [PTRW-1:0]             win_idx;
    logic                        win_vld;
    logic                        grant_vld;
    logic [MXADRB-1:0]           win_adr;
    logic [NSTG-1:0][NREQ-1:0]   tag_pipe;

    // First requesting index found when scanning upward from ptr with wraparound
    always_comb begin : rr_search
        int unsigned idx;
        logic [PTRW-1:0] idx_p;
        idx     = 0;
        idx_p   = '0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_p = PTRW'(idx);
            if (!win_vld && req[idx_p]) begin
                win_vld = 1'b1;
                win_idx = idx_p;
            end
        end
    end

    always_comb begin : adr_mux
        win_adr = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == PTRW'(i)) begin
                win_adr = req_adr[i*MXADRB +: MXADRB];
            end
        end
    end

    // Grant is combinational so the requester sees it in the same cycle it wins
    assign grant_vld = win_vld && !hold && !rsta;
    assign gnt       = grant_vld ? (NREQ'(1) << win_idx) : '0;
    assign rsp_valid = tag_pipe[NSTG-1];
    assign rsp_data  = rom_douta;

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            ptr       <= '0;
            rom_ena   <= 1'b0;
            rom_addra <= '0;
            tag_pipe  <= '0;
            gnt_count <= '0;
        end else begin
            rom_ena <= grant_vld;
            if (grant_vld) begin
                rom_addra <= win_adr;
                ptr       <= (win_idx == PTRW'(NREQ-1)) ? '0 : win_idx + PTRW'(1);
            end

            tag_pipe[0] <= gnt;
            for (int unsigned s = 1; s < NSTG; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end

            // Clear has priority over a grant landing on the same edge
            if (cnt_clr) begin
                gnt_count <= '0;
            end else if (grant_vld && (gnt_count != CNT_MAX)) begin
                gnt_count <= gnt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: vector table for arbitration and pipeline timing,
// plus hand sequences for hold, mid-flight reset and counter saturation/clear.
module tb_rom_arbiter;

    logic        clka;
    logic        rsta;
    logic [3:0]  req;
    logic [35:0] req_adr;
    logic [3:0]  gnt;
    logic        hold;
    logic        rom_ena;
    logic [8:0]  rom_addra;
    logic [10:0] rom_douta;
    logic [3:0]  rsp_valid;
    logic [10:0] rsp_data;
    logic        cnt_clr;
    logic [15:0] gnt_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] adr_tab [4] = '{9'h005, 9'h01A, 9'h133, 9'h1F0};

    typedef struct {
        logic [3:0] req;
        logic       hold;
        logic [3:0] exp_gnt;
    } vec_t;

    vec_t vecs [27];

    rom_arbiter dut (
        .clka      (clka),
        .rsta      (rsta),
        .req       (req),
        .req_adr   (req_adr),
        .gnt       (gnt),
        .hold      (hold),
        .rom_ena   (rom_ena),
        .rom_addra (rom_addra),
        .rom_douta (rom_douta),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .cnt_clr   (cnt_clr),
        .gnt_count (gnt_count)
    );

    initial begin
        clka = 1'b0;
        forever #5 clka = ~clka;
    end

    function automatic logic [10:0] rom_f(input logic [8:0] a);
        if (a == 9'h005) return 11'h3A1;
        return {2'b10, a} ^ 11'h055;
    endfunction

    function automatic logic [8:0] adr_of(input logic [3:0] oh);
        logic [8:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = adr_tab[i];
        end
        return r;
    endfunction

    // Two-cycle synchronous ROM: address registered, then data registered
    logic [8:0] rd_a;
    logic       rd_v;
    always @(posedge clka) begin
        rd_a <= rom_addra;
        rd_v <= rom_ena;
        if (rd_v) rom_douta <= rom_f(rd_a);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [3:0] prev;
        logic [3:0] old;

        vecs[0]  = '{4'b0001, 1'b0, 4'b0001};
        vecs[1]  = '{4'b0000, 1'b0, 4'b0000};
        vecs[2]  = '{4'b0000, 1'b0, 4'b0000};
        vecs[3]  = '{4'b0000, 1'b0, 4'b0000};
        vecs[4]  = '{4'b0010, 1'b0, 4'b0010};
        vecs[5]  = '{4'b0100, 1'b0, 4'b0100};
        vecs[6]  = '{4'b1000, 1'b0, 4'b1000};
        vecs[7]  = '{4'b1111, 1'b0, 4'b0001};
        vecs[8]  = '{4'b1111, 1'b0, 4'b0010};
        vecs[9]  = '{4'b1111, 1'b0, 4'b0100};
        vecs[10] = '{4'b1111, 1'b0, 4'b1000};
        vecs[11] = '{4'b1111, 1'b0, 4'b0001};
        vecs[12] = '{4'b1111, 1'b0, 4'b0010};
        vecs[13] = '{4'b1111, 1'b0, 4'b0100};
        vecs[14] = '{4'b1111, 1'b0, 4'b1000};
        vecs[15] = '{4'b1010, 1'b0, 4'b0010};
        vecs[16] = '{4'b1010, 1'b0, 4'b1000};
        vecs[17] = '{4'b1010, 1'b0, 4'b0010};
        vecs[18] = '{4'b1111, 1'b1, 4'b0000};
        vecs[19] = '{4'b1111, 1'b1, 4'b0000};
        vecs[20] = '{4'b0100, 1'b0, 4'b0100};
        vecs[21] = '{4'b0001, 1'b0, 4'b0001};
        vecs[22] = '{4'b0101, 1'b0, 4'b0100};
        vecs[23] = '{4'b0101, 1'b0, 4'b0001};
        vecs[24] = '{4'b0000, 1'b0, 4'b0000};
        vecs[25] = '{4'b0000, 1'b0, 4'b0000};
        vecs[26] = '{4'b0000, 1'b0, 4'b0000};

        rsta    = 1'b1;
        req     = 4'b1111;
        hold    = 1'b0;
        cnt_clr = 1'b0;
        req_adr = {adr_tab[3], adr_tab[2], adr_tab[1], adr_tab[0]};

        // Reset state
        @(negedge clka); #1;
        check("rst_gnt",       32'(gnt),       32'h0);
        check("rst_rom_ena",   32'(rom_ena),   32'h0);
        check("rst_rom_addra", 32'(rom_addra), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_gnt_count", 32'(gnt_count), 32'h0);
        rsta = 1'b0;
        req  = 4'b0000;

        // Vector table: gnt now, rom port one cycle later, response three cycles later
        for (int k = 0; k < 27; k++) begin
            @(negedge clka);
            req  = vecs[k].req;
            hold = vecs[k].hold;
            #1;
            prev = (k >= 1) ? vecs[k-1].exp_gnt : 4'b0000;
            old  = (k >= 3) ? vecs[k-3].exp_gnt : 4'b0000;
            check($sformatf("v%0d_gnt", k),       32'(gnt),       32'(vecs[k].exp_gnt));
            check($sformatf("v%0d_rom_ena", k),   32'(rom_ena),   32'(|prev));
            if (|prev)
                check($sformatf("v%0d_rom_addra", k), 32'(rom_addra), 32'(adr_of(prev)));
            check($sformatf("v%0d_rsp_valid", k), 32'(rsp_valid), 32'(old));
            if (|old)
                check($sformatf("v%0d_rsp_data", k), 32'(rsp_data), 32'(rom_f(adr_of(old))));
        end
        hold = 1'b0;
        req  = 4'b0000;
        @(negedge clka); #1;
        check("table_gnt_count", 32'(gnt_count), 32'd19);

        // Hold after a grant: the in-flight read still returns
        @(negedge clka);
        req = 4'b0001;
        #1;
        check("hold_gnt0", 32'(gnt), 32'b0001);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clka);
            hold = 1'b1;
            req  = 4'b1111;
            #1;
            check($sformatf("hold%0d_gnt", j),       32'(gnt),       32'h0);
            check($sformatf("hold%0d_rom_ena", j),   32'(rom_ena),   32'(j == 1));
            check($sformatf("hold%0d_rsp_valid", j), 32'(rsp_valid), (j == 3) ? 32'b0001 : 32'h0);
            if (j == 1) check("hold_rom_addra", 32'(rom_addra), 32'h005);
            if (j == 3) check("hold_rsp_data",  32'(rsp_data),  32'h3A1);
        end
        hold = 1'b0;
        req  = 4'b0000;
        @(negedge clka);
        @(negedge clka);

        // Reset pulse right after a grant discards the read
        @(negedge clka);
        req = 4'b0001;
        #1;
        check("rstp_gnt0", 32'(gnt), 32'b0001);
        @(negedge clka);
        rsta = 1'b1;
        req  = 4'b1111;
        #1;
        check("rstp_gnt_in_rst", 32'(gnt),       32'h0);
        check("rstp_rom_ena",    32'(rom_ena),   32'h0);
        check("rstp_rom_addra",  32'(rom_addra), 32'h0);
        check("rstp_gnt_count",  32'(gnt_count), 32'h0);
        for (int j = 2; j <= 5; j++) begin
            @(negedge clka);
            rsta = 1'b0;
            req  = 4'b0000;
            #1;
            check($sformatf("rstp%0d_rsp_valid", j), 32'(rsp_valid), 32'h0);
        end
        @(negedge clka);
        req = 4'b1111;
        #1;
        check("rstp_first_gnt", 32'(gnt), 32'b0001);

        // Counter saturation and clear priority
        @(negedge clka);
        req     = 4'b0000;
        cnt_clr = 1'b1;
        @(negedge clka);
        cnt_clr = 1'b0;
        #1;
        check("cnt_cleared", 32'(gnt_count), 32'h0);
        req = 4'b0001;
        repeat (65531) @(negedge clka);
        #1;
        check("cnt_fffb", 32'(gnt_count), 32'hFFFB);
        repeat (3) @(negedge clka);
        #1;
        check("cnt_fffe", 32'(gnt_count), 32'hFFFE);
        @(negedge clka); #1;
        check("cnt_ffff", 32'(gnt_count), 32'hFFFF);
        repeat (2) @(negedge clka);
        #1;
        check("cnt_sat", 32'(gnt_count), 32'hFFFF);
        cnt_clr = 1'b1;
        check("cnt_clr_gnt", 32'(gnt), 32'b0001);
        @(negedge clka);
        cnt_clr = 1'b0;
        #1;
        check("cnt_clr_wins", 32'(gnt_count), 32'h0);
        @(negedge clka); #1;
        check("cnt_after_clr", 32'(gnt_count), 32'h1);
        req = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one ROM port (2..8).
REQ-002 Parameter MXADRB, default 9, ROM address width.
REQ-003 Parameter MXDATB, default 11, ROM data width.
REQ-004 Parameter RD_LATENCY, default 2, ROM cycles from registered ena/addra to valid douta.
REQ-005 clka  input  1  single clock; all logic on rising edge.
REQ-006 rsta  input  1  reset, asynchronous, active-high.
REQ-007 req  input  NREQ  per-requester read request, level, held until granted.
REQ-008 req_adr  input  NREQ*MXADRB  per-requester address; requester i uses bits [i*MXADRB +: MXADRB].
REQ-009 gnt  output  NREQ  one-hot grant, combinational, same cycle as the winning req.
REQ-010 hold  input  1  freezes arbitration when high; in-flight reads complete.
REQ-011 rom_ena  output  1  registered ROM read enable.
REQ-012 rom_addra  output  MXADRB  registered ROM address.
REQ-013 rom_douta  input  MXDATB  ROM read data.
REQ-014 rsp_valid  output  NREQ  one-hot response strobe, one cycle per granted read.
REQ-015 rsp_data  output  MXDATB  response data, shared by all requesters, equal to rom_douta.
REQ-016 cnt_clr  input  1  synchronous clear of gnt_count.
REQ-017 gnt_count  output  16  saturating count of grants issued.

Function
REQ-018 Grant cycle N: when hold=0 and req!=0, exactly one gnt bit SHALL assert, chosen by round-robin search starting at pointer ptr.
REQ-019 After a grant to i, ptr SHALL become (i+1) mod NREQ at the next edge; with no grant, ptr SHALL be unchanged.
REQ-020 hold=1 or req=0: gnt SHALL be all zero and ptr unchanged.
REQ-021 Cycle N+1: rom_ena SHALL be 1 and rom_addra SHALL equal the granted requester's req_adr sampled in cycle N; with no grant in N, rom_ena SHALL be 0 and rom_addra SHALL hold its last value.
REQ-022 A requester SHALL see gnt for one cycle per read; req still high in N+1 is a new request.
REQ-023 The block SHALL carry a one-hot requester tag through a RD_LATENCY+1 stage shift pipeline, so that rsp_valid[i] asserts in cycle N+1+RD_LATENCY (N+3 at default).
REQ-024 rsp_data SHALL be rom_douta combinationally; rsp_data is defined only while rsp_valid!=0.
REQ-025 Throughput: one grant per cycle sustained; back-to-back grants SHALL produce back-to-back rsp_valid in grant order.
REQ-026 No response backpressure; every grant SHALL produce exactly one rsp_valid pulse.
REQ-027 Single requester with req held high SHALL be granted every cycle.
REQ-028 hold rising SHALL NOT cancel a grant already issued; responses for prior grants SHALL still appear.
REQ-029 gnt_count SHALL increment by 1 per grant, saturate at 0xFFFF, and not wrap.
REQ-030 cnt_clr=1 SHALL load gnt_count=0 at the next edge; clear wins over a simultaneous grant.

Reset
REQ-031 rsta=1 SHALL immediately force rom_ena=0, rom_addra=0, tag pipeline=0, rsp_valid=0, ptr=0, gnt_count=0.
REQ-032 gnt SHALL be 0 while rsta=1.
REQ-033 Reset mid-operation SHALL discard in-flight reads; no rsp_valid SHALL follow for reads granted before reset.
REQ-034 First grant after reset release SHALL search from requester 0.

Verification
REQ-035 Reset release, req=4'b0001, adr0=0x005, ROM[5]=0x3A1 -> gnt=0001 in cycle N, rom_ena=1/rom_addra=0x005 in N+1, rsp_valid=0001 with rsp_data=0x3A1 in N+3.
REQ-036 req=4'b1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,...; rsp_valid the same sequence delayed 3 cycles; gnt_count=8.
REQ-037 req=4'b1010 with ptr=0 -> grants 0010,1000,0010; requesters 0 and 2 never granted.
REQ-038 Grant in cycle N, hold=1 in N+1..N+5 -> no further gnt, rom_ena=0 from N+2, rsp_valid for the cycle-N grant still in N+3.
REQ-039 rsta pulsed in N+1 after a cycle-N grant -> rsp_valid stays 0 through N+5; next grant goes to requester 0 when req=1111.
REQ-040 gnt_count preloaded to 0xFFFE by 3 grants from 0xFFFB -> increments to 0xFFFF and holds; cnt_clr with a simultaneous grant -> 0x0000.
